// File: rtl/brew_arbiter_if.sv
// brew_arbiter_if: station/brew-unit signal bundle for brew_arbiter
//   master: drives req0/req1/brew_ready, observes grants, pulses and status
//   slave : the arbiter side (inputs req0/req1/brew_ready, drives the rest)
interface brew_arbiter_if;
    logic       req0;
    logic       req1;
    logic       brew_ready;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic       brew_start;
    logic       busy;
    logic       err;
    logic [2:0] state;
    logic [3:0] cups;
    logic       empty;
    modport master (
        output req0, req1, brew_ready,
        input  gnt0, gnt1, done0, done1, brew_start, busy, err, state, cups, empty
    );
    modport slave (
        input  req0, req1, brew_ready,
        output gnt0, gnt1, done0, done1, brew_start, busy, err, state, cups, empty
    );
endinterface

// File: rtl/brew_arbiter.sv
// brew_arbiter: round-robin arbiter giving two vending stations turns on one brew unit
//   clk, reset : single clock, synchronous active-high reset
//   bus.slave  : req0/req1 level requests, brew_ready completion from the brew unit;
//                gnt0/gnt1 ownership, done0/done1 and brew_start pulses,
//                busy, sticky err (brew timeout), debug state, cups/empty inventory
//   Macro CUP_COUNT_EN enables cup inventory counting and empty blocking;
//   without it cups and empty are tied to 0 and grants are never blocked.
module brew_arbiter #(
    parameter int         BREW_TIMEOUT = 16,
    parameter logic [3:0] CUPS_INIT    = 4'd15
) (
    input  logic          clk,
    input  logic          reset,
    brew_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, BREW = 3'd2, DONE = 3'd3} state_t;
    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       sel_q, sel_d, last_q, last_d, err_q, err_d;
    logic       gnt0_q, gnt1_q, done0_q, done1_q, start_q, busy_q;
    logic       win, blocked;
`ifdef CUP_COUNT_EN
    logic [3:0] cups_q, cups_d;
    logic       empty_q, ok;
    // only a brew that finished via brew_ready consumes a cup
    assign ok      = state_q == BREW && bus.brew_ready;
    assign cups_d  = (ok && cups_q != 4'd0) ? cups_q - 4'd1 : cups_q;
    assign blocked = empty_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            cups_q  <= CUPS_INIT;
            empty_q <= CUPS_INIT == 4'd0;
        end else begin
            cups_q  <= cups_d;
            empty_q <= cups_d == 4'd0;
        end
    end
    assign bus.cups  = cups_q;
    assign bus.empty = empty_q;
`else
    assign blocked   = 1'b0;
    assign bus.cups  = 4'd0;
    assign bus.empty = 1'b0;
`endif
    // on a tie the station not served last wins
    assign win    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    assign last_d = state_q == DONE ? sel_q : last_q;
    always_comb begin
        state_d = IDLE;
        timer_d = timer_q;
        sel_d   = sel_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if ((bus.req0 || bus.req1) && !blocked) begin
                    state_d = START;
                    sel_d   = win;
                end
            end
            START: begin
                state_d = BREW;
                timer_d = 8'd0;
            end
            BREW: begin
                timer_d = timer_q + 8'd1;
                // brew_ready on the final timer value still counts as success
                state_d = (bus.brew_ready || timer_q == 8'(BREW_TIMEOUT - 1)) ? DONE : BREW;
                err_d   = err_q || (!bus.brew_ready && timer_q == 8'(BREW_TIMEOUT - 1));
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= 8'd0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            err_q   <= err_d;
            gnt0_q  <= state_d != IDLE && !sel_d;
            gnt1_q  <= state_d != IDLE && sel_d;
            done0_q <= state_d == DONE && !sel_d;
            done1_q <= state_d == DONE && sel_d;
            start_q <= state_d == START;
            busy_q  <= state_d != IDLE;
        end
    end
    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.done0      = done0_q;
    assign bus.done1      = done1_q;
    assign bus.brew_start = start_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
    assign bus.state      = state_q;
endmodule

// File: doc/brew_arbiter.md
BREW_ARBITER -- requirements
Module: brew_arbiter

Interface
REQ-001 Parameter BREW_TIMEOUT, default 16, max cycles in BREW awaiting brew_ready (range 2..255).
REQ-002 Parameter CUPS_INIT, default 15, cup inventory loaded at reset (4-bit, 0..15).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  vending station 0 requests a beverage; level, held until done0.
REQ-006 req1  input  1  vending station 1 requests a beverage; level, held until done1.
REQ-007 brew_ready  input  1  brew unit reports beverage complete; sampled only in BREW.
REQ-008 gnt0, gnt1  output  1 each  station currently owns brew unit; mutually exclusive.
REQ-009 done0, done1  output  1 each  one-cycle pulse, service of that station finished.
REQ-010 brew_start  output  1  one-cycle pulse commanding brew unit to start.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 err  output  1  sticky, set on brew timeout.
REQ-013 state  output  3  current FSM state encoding, for debug.
REQ-014 cups  output  4  remaining cup inventory.
REQ-015 empty  output  1  high when cups == 0.

Function
REQ-016 FSM states SHALL be IDLE=0, START=1, BREW=2, DONE=3; encodings 4..7 SHALL return to IDLE next cycle.
REQ-017 All outputs SHALL be registered.
REQ-018 IDLE: if empty=0 and any req high, SHALL select a winner and go to START next cycle; else stay.
REQ-019 Arbitration SHALL be round-robin: with both requests high, the station not served last wins; with one high, it wins.
REQ-020 Last-served pointer SHALL reset to station 1 so station 0 wins the first tie.
REQ-021 Selected gnt SHALL be high from START through DONE inclusive, low in IDLE.
REQ-022 START: brew_start SHALL be high for exactly that one cycle; next state BREW; timer cleared to 0.
REQ-023 BREW: timer SHALL increment each cycle; brew_ready=1 -> DONE.
REQ-024 BREW: if timer reaches BREW_TIMEOUT-1 with brew_ready=0, SHALL go to DONE and set err.
REQ-025 brew_ready at timer == BREW_TIMEOUT-1 SHALL count as success, no err.
REQ-026 DONE: done pulse of granted station high one cycle; pointer updated to granted station; next state IDLE.
REQ-027 req0 to brew_start latency SHALL be exactly 1 cycle from IDLE sampling.
REQ-028 Dropping req during START/BREW/DONE SHALL NOT abort service.
REQ-029 brew_ready outside BREW SHALL be ignored.
REQ-030 A req still high in IDLE after done SHALL be treated as a new request.
REQ-031 Minimum service IDLE->IDLE SHALL be 4 cycles (brew_ready high on first BREW cycle).

Reset
REQ-032 Reset SHALL force state=IDLE, gnt0=gnt1=0, done0=done1=0, brew_start=0, busy=0, err=0, timer=0, pointer=station 1.
REQ-033 Reset SHALL load cups=CUPS_INIT; empty = (CUPS_INIT==0).
REQ-034 Reset mid-service SHALL abandon the service with no done pulse and no cup decrement.
REQ-035 Reset SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-036 Macro CUP_COUNT_EN defined: DONE without timeout SHALL decrement cups by 1 (saturating at 0); timeout SHALL NOT decrement; empty=1 SHALL block new grants in IDLE.
REQ-037 Macro CUP_COUNT_EN undefined: cups SHALL be constant 0, empty constant 0, grants never blocked, no inventory register.

Verification
REQ-038 Reset, req0=1 one cycle later, brew_ready=1 on 3rd BREW cycle -> brew_start pulse 1 cycle after req0, gnt0 high 5 cycles, done0 pulse, err=0, cups 15->14 (CUP_COUNT_EN).
REQ-039 req0=req1=1 simultaneously from reset, both held until done -> service order 0,1,0,1; gnt never both high.
REQ-040 req1 only, brew_ready never asserted, BREW_TIMEOUT=16 -> DONE after 16 BREW cycles, done1 pulse, err=1 sticky, cups unchanged.
REQ-041 CUPS_INIT=1, CUP_COUNT_EN: one successful service then req0 -> cups=0, empty=1, req0 ignored, busy=0.
REQ-042 reset asserted during BREW -> next cycle state=0, gnt=0, no done pulse, cups=CUPS_INIT.
REQ-043 brew_ready=1 pulsed while IDLE and START -> no state change beyond normal sequence, no done pulse.
